// File: rtl/key_dispatch.sv
// ============================================================================
// key_dispatch
// ----------------------------------------------------------------------------
// Turns a stream of USB HID keyboard report bytes into one stable 8-bit
// keycode per tank, updated once per frame.
//   player 0: W/S/A/D = 1A/16/04/07, fire (Space) = 2C
//   player 1: Up/Down/Left/Right = 52/51/50/4F, fire (Enter) = 28
// A player holding a move key and fire sees the two codes alternate frame by
// frame, fire first. If no report is committed for STALE_FRAMES frame edges,
// every output is forced to 8'h00 and 'stale' is raised.
//
// Optional feature macro: KEY_DISPATCH_FIRE_LATCH_EN
//   defined   - a fire tap committed anywhere inside a frame is held until the
//               next snapshot, so even a sub-frame tap is emitted once.
//   undefined - fire follows only the last committed report.
//
// Parameters
//   MAX_KEYS      key bytes classified per report (1..7); later bytes ignored
//   STALE_FRAMES  frame edges without a commit before outputs are cleared
//
// Ports
//   Clk         in   1  system clock (50 MHz)
//   Reset       in   1  synchronous, active-high reset
//   frame_clk   in   1  ~60 Hz frame clock level, rising edge detected here
//   kb_valid    in   1  kb_byte carries a report byte this cycle
//   kb_byte     in   8  one HID keycode of the current report
//   kb_last     in   1  with kb_valid: this byte ends the report
//   keycode_p0  out  8  player-0 keycode (00/1A/16/04/07/2C)
//   keycode_p1  out  8  player-1 keycode (00/52/51/50/4F/28)
//   stale       out  1  high while the stale counter is saturated
// ============================================================================
module key_dispatch #(
    parameter int MAX_KEYS     = 6,
    parameter int STALE_FRAMES = 30
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       kb_valid,
    input  logic [7:0] kb_byte,
    input  logic       kb_last,
    output logic [7:0] keycode_p0,
    output logic [7:0] keycode_p1,
    output logic       stale
);

    localparam logic [7:0]     KEY_ROLLOVER = 8'h01;
    localparam logic [7:0]     P0_FIRE      = 8'h2C;
    localparam logic [7:0]     P1_FIRE      = 8'h28;
    localparam logic [2:0]     KEY_LIMIT    = 3'(MAX_KEYS);
    localparam int             SCW          = $clog2(STALE_FRAMES + 1);
    localparam logic [SCW-1:0] STALE_MAX    = SCW'(STALE_FRAMES);
    localparam logic [SCW-1:0] STALE_EDGE   = SCW'(STALE_FRAMES - 1);
    localparam logic [SCW-1:0] STALE_ONE    = SCW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        ERROR = 2'd2
    } state_t;

    // Player-0 movement code, or 00 if the byte is not a player-0 move key.
    function automatic logic [7:0] p0_move(input logic [7:0] code);
        logic [7:0] r;
        case (code)
            8'h1A, 8'h16, 8'h04, 8'h07: r = code;
            default:                    r = 8'h00;
        endcase
        return r;
    endfunction

    // Player-1 movement code, or 00 if the byte is not a player-1 move key.
    function automatic logic [7:0] p1_move(input logic [7:0] code);
        logic [7:0] r;
        case (code)
            8'h52, 8'h51, 8'h50, 8'h4F: r = code;
            default:                    r = 8'h00;
        endcase
        return r;
    endfunction

    // Frame snapshot for one player: returns {alt_next, keycode}.
    // mv is 00 when no move key is held, so "move only" and "nothing held"
    // share the last branch.
    function automatic logic [8:0] snapshot(input logic       fire,
                                            input logic [7:0] mv,
                                            input logic       alt,
                                            input logic [7:0] fire_code);
        logic [8:0] r;
        if (fire && (mv != 8'h00)) begin
            r = {~alt, (alt ? mv : fire_code)};
        end else if (fire) begin
            r = {1'b0, fire_code};
        end else begin
            r = {1'b0, mv};
        end
        return r;
    endfunction

    state_t         state_r;
    state_t         state_next_s;
    logic           commit_s;
    logic           acc_clear_s;
    logic           acc_update_s;
    logic           rollover_s;
    logic           in_range_s;
    logic           classify_s;

    logic [2:0]     byte_cnt_r;
    logic [7:0]     mv_acc_p0_r,  mv_acc_p1_r;
    logic           fire_acc_p0_r, fire_acc_p1_r;
    logic [7:0]     mv_next_p0_s, mv_next_p1_s;
    logic           fire_next_p0_s, fire_next_p1_s;

    logic [7:0]     pend_mv_p0_r, pend_mv_p1_r;
    logic           pend_fire_p0_r, pend_fire_p1_r;
    logic           eff_fire_p0_s, eff_fire_p1_s;
    logic [SCW-1:0] stale_cnt_r;
    logic           stale_r;

    logic           frame_clk_delayed_r;
    logic           fpulse_r;

    logic           alt_p0_r, alt_p1_r;
    logic [7:0]     out_p0_r, out_p1_r;
    logic [8:0]     snap_p0_s, snap_p1_s;

    assign rollover_s = kb_valid && (kb_byte == KEY_ROLLOVER);
    assign in_range_s = (byte_cnt_r < KEY_LIMIT);
    assign classify_s = (acc_update_s || commit_s) && in_range_s;

    // Merge the current byte into the accumulators; the first move key wins.
    always_comb begin
        mv_next_p0_s   = mv_acc_p0_r;
        mv_next_p1_s   = mv_acc_p1_r;
        fire_next_p0_s = fire_acc_p0_r;
        fire_next_p1_s = fire_acc_p1_r;
        if (classify_s) begin
            mv_next_p0_s   = (mv_acc_p0_r != 8'h00) ? mv_acc_p0_r : p0_move(kb_byte);
            mv_next_p1_s   = (mv_acc_p1_r != 8'h00) ? mv_acc_p1_r : p1_move(kb_byte);
            fire_next_p0_s = fire_acc_p0_r | (kb_byte == P0_FIRE);
            fire_next_p1_s = fire_acc_p1_r | (kb_byte == P1_FIRE);
        end else begin
            mv_next_p0_s   = mv_acc_p0_r;
            mv_next_p1_s   = mv_acc_p1_r;
            fire_next_p0_s = fire_acc_p0_r;
            fire_next_p1_s = fire_acc_p1_r;
        end
    end

    // Accumulator FSM state register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Accumulator FSM next state. kb_last always returns to IDLE, even from ERROR.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE, ACCUM: begin
                if (kb_valid && kb_last) begin
                    state_next_s = IDLE;
                end else if (rollover_s) begin
                    state_next_s = ERROR;
                end else if (kb_valid) begin
                    state_next_s = ACCUM;
                end else begin
                    state_next_s = state_r;
                end
            end
            ERROR: begin
                if (kb_valid && kb_last) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = ERROR;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Accumulator FSM outputs. A rollover byte poisons the whole report, so it
    // never commits even when it carries kb_last; ERROR keeps accumulators clear.
    always_comb begin
        commit_s     = 1'b0;
        acc_clear_s  = 1'b0;
        acc_update_s = 1'b0;
        case (state_r)
            IDLE, ACCUM: begin
                if (rollover_s) begin
                    acc_clear_s = 1'b1;
                end else if (kb_valid && kb_last) begin
                    commit_s    = 1'b1;
                    acc_clear_s = 1'b1;
                end else if (kb_valid) begin
                    acc_update_s = 1'b1;
                end else begin
                    acc_update_s = 1'b0;
                end
            end
            ERROR:   acc_clear_s = 1'b1;
            default: acc_clear_s = 1'b1;
        endcase
    end

    // Per-report accumulators and byte counter (saturates so long reports never wrap).
    always_ff @(posedge Clk) begin
        if (Reset) begin
            byte_cnt_r    <= 3'd0;
            mv_acc_p0_r   <= 8'h00;
            mv_acc_p1_r   <= 8'h00;
            fire_acc_p0_r <= 1'b0;
            fire_acc_p1_r <= 1'b0;
        end else if (acc_clear_s) begin
            byte_cnt_r    <= 3'd0;
            mv_acc_p0_r   <= 8'h00;
            mv_acc_p1_r   <= 8'h00;
            fire_acc_p0_r <= 1'b0;
            fire_acc_p1_r <= 1'b0;
        end else if (acc_update_s) begin
            byte_cnt_r    <= (byte_cnt_r == 3'd7) ? byte_cnt_r : byte_cnt_r + 3'd1;
            mv_acc_p0_r   <= mv_next_p0_s;
            mv_acc_p1_r   <= mv_next_p1_s;
            fire_acc_p0_r <= fire_next_p0_s;
            fire_acc_p1_r <= fire_next_p1_s;
        end else begin
            byte_cnt_r    <= byte_cnt_r;
            mv_acc_p0_r   <= mv_acc_p0_r;
            mv_acc_p1_r   <= mv_acc_p1_r;
            fire_acc_p0_r <= fire_acc_p0_r;
            fire_acc_p1_r <= fire_acc_p1_r;
        end
    end

    // Frame edge detector; fpulse is high for one Clk after a frame_clk rise.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_clk_delayed_r <= 1'b0;
            fpulse_r            <= 1'b0;
        end else begin
            frame_clk_delayed_r <= frame_clk;
            fpulse_r            <= frame_clk & ~frame_clk_delayed_r;
        end
    end

    // Pending keys and stale counter. A commit takes priority over a frame pulse
    // in the same cycle; the snapshot still sees the old pending values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pend_mv_p0_r   <= 8'h00;
            pend_mv_p1_r   <= 8'h00;
            pend_fire_p0_r <= 1'b0;
            pend_fire_p1_r <= 1'b0;
            stale_cnt_r    <= '0;
            stale_r        <= 1'b0;
        end else if (commit_s) begin
            pend_mv_p0_r   <= mv_next_p0_s;
            pend_mv_p1_r   <= mv_next_p1_s;
            pend_fire_p0_r <= fire_next_p0_s;
            pend_fire_p1_r <= fire_next_p1_s;
            stale_cnt_r    <= '0;
            stale_r        <= 1'b0;
        end else if (fpulse_r && (stale_cnt_r >= STALE_EDGE)) begin
            pend_mv_p0_r   <= 8'h00;
            pend_mv_p1_r   <= 8'h00;
            pend_fire_p0_r <= 1'b0;
            pend_fire_p1_r <= 1'b0;
            stale_cnt_r    <= STALE_MAX;
            stale_r        <= 1'b1;
        end else if (fpulse_r) begin
            pend_mv_p0_r   <= pend_mv_p0_r;
            pend_mv_p1_r   <= pend_mv_p1_r;
            pend_fire_p0_r <= pend_fire_p0_r;
            pend_fire_p1_r <= pend_fire_p1_r;
            stale_cnt_r    <= stale_cnt_r + STALE_ONE;
            stale_r        <= stale_r;
        end else begin
            pend_mv_p0_r   <= pend_mv_p0_r;
            pend_mv_p1_r   <= pend_mv_p1_r;
            pend_fire_p0_r <= pend_fire_p0_r;
            pend_fire_p1_r <= pend_fire_p1_r;
            stale_cnt_r    <= stale_cnt_r;
            stale_r        <= stale_r;
        end
    end

`ifdef KEY_DISPATCH_FIRE_LATCH_EN
    logic fire_latch_p0_r, fire_latch_p1_r;

    // Sticky fire: set by any committed fire, cleared by a snapshot unless a
    // commit in the same cycle sets it again (that tap belongs to the next frame).
    always_ff @(posedge Clk) begin
        if (Reset) begin
            fire_latch_p0_r <= 1'b0;
            fire_latch_p1_r <= 1'b0;
        end else if (commit_s) begin
            fire_latch_p0_r <= fire_next_p0_s | (fire_latch_p0_r & ~fpulse_r);
            fire_latch_p1_r <= fire_next_p1_s | (fire_latch_p1_r & ~fpulse_r);
        end else if (fpulse_r) begin
            fire_latch_p0_r <= 1'b0;
            fire_latch_p1_r <= 1'b0;
        end else begin
            fire_latch_p0_r <= fire_latch_p0_r;
            fire_latch_p1_r <= fire_latch_p1_r;
        end
    end

    assign eff_fire_p0_s = pend_fire_p0_r | fire_latch_p0_r;
    assign eff_fire_p1_s = pend_fire_p1_r | fire_latch_p1_r;
`else
    assign eff_fire_p0_s = pend_fire_p0_r;
    assign eff_fire_p1_s = pend_fire_p1_r;
`endif

    assign snap_p0_s = snapshot(eff_fire_p0_s, pend_mv_p0_r, alt_p0_r, P0_FIRE);
    assign snap_p1_s = snapshot(eff_fire_p1_s, pend_mv_p1_r, alt_p1_r, P1_FIRE);

    // Output snapshot registers, loaded only on a frame pulse.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            out_p0_r <= 8'h00;
            out_p1_r <= 8'h00;
            alt_p0_r <= 1'b0;
            alt_p1_r <= 1'b0;
        end else if (fpulse_r) begin
            out_p0_r <= snap_p0_s[7:0];
            out_p1_r <= snap_p1_s[7:0];
            alt_p0_r <= snap_p0_s[8];
            alt_p1_r <= snap_p1_s[8];
        end else begin
            out_p0_r <= out_p0_r;
            out_p1_r <= out_p1_r;
            alt_p0_r <= alt_p0_r;
            alt_p1_r <= alt_p1_r;
        end
    end

    assign keycode_p0 = out_p0_r;
    assign keycode_p1 = out_p1_r;
    assign stale      = stale_r;

endmodule

// File: tb/tb_key_dispatch.sv
// ============================================================================
// tb_key_dispatch
// Self-checking bench for key_dispatch: a table of single-report vectors,
// hand-written multi-cycle sequences, and a random phase, all compared every
// cycle against a report-level reference model.
// ============================================================================
module tb_key_dispatch;

    localparam int MAX_KEYS     = 6;
    localparam int STALE_FRAMES = 30;
`ifdef KEY_DISPATCH_FIRE_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_clk;
    logic       kb_valid;
    logic [7:0] kb_byte;
    logic       kb_last;
    logic [7:0] keycode_p0;
    logic [7:0] keycode_p1;
    logic       stale;

    always #10 Clk = ~Clk;

    key_dispatch #(.MAX_KEYS(MAX_KEYS), .STALE_FRAMES(STALE_FRAMES)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .kb_valid   (kb_valid),
        .kb_byte    (kb_byte),
        .kb_last    (kb_last),
        .keycode_p0 (keycode_p0),
        .keycode_p1 (keycode_p1),
        .stale      (stale)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic fl = 1'b0;

    // ---------------- reference model (report level) ----------------
    logic [7:0] m_q[$];
    bit         m_err;
    logic [7:0] m_pmv[2];
    bit         m_pfire[2];
    bit         m_latch[2];
    bit         m_alt[2];
    logic [7:0] m_out[2];
    int         m_scnt;
    bit         m_stale;
    bit         m_fd, m_fp;

    function automatic bit is_move(input int p, input logic [7:0] c);
        if (p == 0) return (c == 8'h1A) || (c == 8'h16) || (c == 8'h04) || (c == 8'h07);
        return (c == 8'h52) || (c == 8'h51) || (c == 8'h50) || (c == 8'h4F);
    endfunction

    function automatic logic [7:0] fire_code(input int p);
        return (p == 0) ? 8'h2C : 8'h28;
    endfunction

    task automatic model_edge();
        bit         fp;
        bit         commit;
        logic [7:0] nmv[2];
        bit         nfire[2];
        if (Reset) begin
            m_q.delete();
            m_err = 0; m_scnt = 0; m_stale = 0; m_fd = 0; m_fp = 0;
            for (int p = 0; p < 2; p++) begin
                m_pmv[p] = 8'h00; m_pfire[p] = 0; m_latch[p] = 0; m_alt[p] = 0; m_out[p] = 8'h00;
            end
            return;
        end
        fp = m_fp;
        commit = 0;
        nmv[0] = 8'h00; nmv[1] = 8'h00; nfire[0] = 0; nfire[1] = 0;
        if (kb_valid) begin
            if (m_err) begin
                if (kb_last) m_err = 0;
            end else if (kb_byte == 8'h01) begin
                m_q.delete();
                m_err = !kb_last;
            end else begin
                m_q.push_back(kb_byte);
                if (kb_last) begin
                    commit = 1;
                    for (int i = 0; i < m_q.size() && i < MAX_KEYS; i++) begin
                        for (int p = 0; p < 2; p++) begin
                            if (is_move(p, m_q[i]) && nmv[p] == 8'h00) nmv[p] = m_q[i];
                            if (m_q[i] == fire_code(p)) nfire[p] = 1;
                        end
                    end
                    m_q.delete();
                end
            end
        end
        if (fp) begin
            for (int p = 0; p < 2; p++) begin
                bit f;
                f = m_pfire[p] | m_latch[p];
                if (f && m_pmv[p] != 8'h00) begin
                    m_out[p] = m_alt[p] ? m_pmv[p] : fire_code(p);
                    m_alt[p] = !m_alt[p];
                end else if (f) begin
                    m_out[p] = fire_code(p); m_alt[p] = 0;
                end else begin
                    m_out[p] = m_pmv[p]; m_alt[p] = 0;
                end
            end
        end
        if (commit) begin
            for (int p = 0; p < 2; p++) begin
                m_pmv[p] = nmv[p];
                m_pfire[p] = nfire[p];
                if (LATCH) m_latch[p] = nfire[p] | (m_latch[p] & !fp);
            end
            m_scnt = 0; m_stale = 0;
        end else if (fp) begin
            m_scnt = m_scnt + 1;
            for (int p = 0; p < 2; p++) m_latch[p] = 0;
            if (m_scnt >= STALE_FRAMES) begin
                m_scnt = STALE_FRAMES; m_stale = 1;
                for (int p = 0; p < 2; p++) begin m_pmv[p] = 8'h00; m_pfire[p] = 0; end
            end
        end
        m_fp = frame_clk & !m_fd;
        m_fd = frame_clk;
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] b, input logic l, input logic f, input logic r);
        kb_valid = v; kb_byte = b; kb_last = l; frame_clk = f; Reset = r;
        @(posedge Clk);
        model_edge();
        @(negedge Clk);
        chk("p0_vs_model", keycode_p0, m_out[0]);
        chk("p1_vs_model", keycode_p1, m_out[1]);
        chk("stale_vs_model", {7'd0, stale}, {7'd0, m_stale});
    endtask

    task automatic send(input logic [63:0] bytes, input int n);
        for (int i = 0; i < n; i++) step(1'b1, bytes[8*i +: 8], (i == n - 1), fl, 1'b0);
    endtask

    task automatic frame();
        fl = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, fl, 1'b0);
        fl = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, fl, 1'b0);
    endtask

    typedef struct packed {
        logic [63:0] b;    // report bytes, first byte in [7:0]
        logic [3:0]  n;    // byte count (0 = no report this frame)
        logic [7:0]  e0;   // expected keycode_p0 after the next frame
        logic [7:0]  e1;   // expected keycode_p1 after the next frame
    } vec_t;

    vec_t       vecs[13];
    logic [7:0] codes[16];

    initial begin
        vecs[0]  = '{b: 64'h2C1A,               n: 4'd2, e0: 8'h2C, e1: 8'h00};
        vecs[1]  = '{b: 64'h0,                  n: 4'd0, e0: 8'h1A, e1: 8'h00};
        vecs[2]  = '{b: 64'h0,                  n: 4'd0, e0: 8'h2C, e1: 8'h00};
        vecs[3]  = '{b: 64'h045152,             n: 4'd3, e0: 8'h04, e1: 8'h52};
        vecs[4]  = '{b: 64'h00,                 n: 4'd1, e0: 8'h00, e1: 8'h00};
        vecs[5]  = '{b: 64'h07,                 n: 4'd1, e0: 8'h07, e1: 8'h00};
        vecs[6]  = '{b: 64'h0701,               n: 4'd2, e0: 8'h07, e1: 8'h00};
        vecs[7]  = '{b: 64'h16,                 n: 4'd1, e0: 8'h16, e1: 8'h00};
        vecs[8]  = '{b: 64'h5028,               n: 4'd2, e0: 8'h00, e1: 8'h28};
        vecs[9]  = '{b: 64'h0,                  n: 4'd0, e0: 8'h00, e1: 8'h50};
        vecs[10] = '{b: 64'h0016_0000_0000_0000, n: 4'd8, e0: 8'h00, e1: 8'h00};
        vecs[11] = '{b: 64'h4F282C1A04,         n: 4'd5, e0: 8'h2C, e1: 8'h28};
        vecs[12] = '{b: 64'h0,                  n: 4'd0, e0: 8'h04, e1: 8'h4F};
        codes = '{8'h1A, 8'h16, 8'h04, 8'h07, 8'h2C, 8'h52, 8'h51, 8'h50,
                  8'h4F, 8'h28, 8'h00, 8'h01, 8'h1A, 8'h4F, 8'h2C, 8'h28};

        // reset state
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("reset_p0", keycode_p0, 8'h00);
        chk("reset_p1", keycode_p1, 8'h00);
        chk("reset_stale", {7'd0, stale}, 8'h00);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // table-driven reports, one frame each
        for (int i = 0; i < 13; i++) begin
            send(vecs[i].b, int'(vecs[i].n));
            frame();
            chk($sformatf("vec%0d_p0", i), keycode_p0, vecs[i].e0);
            chk($sformatf("vec%0d_p1", i), keycode_p1, vecs[i].e1);
        end

        // two reports inside one frame: fire tap then move
        send(64'h2C, 1);
        send(64'h1A, 1);
        frame();
`ifdef KEY_DISPATCH_FIRE_LATCH_EN
        chk("latch_tap_p0", keycode_p0, 8'h2C);
        frame();
        chk("latch_after_p0", keycode_p0, 8'h1A);
`else
        chk("last_report_p0", keycode_p0, 8'h1A);
`endif

        // stale timeout
        send(64'h4F, 1);
        for (int k = 1; k <= 29; k++) frame();
        chk("stale_29", {7'd0, stale}, 8'h00);
        chk("stale_29_p1", keycode_p1, 8'h4F);
        frame();
        chk("stale_30", {7'd0, stale}, 8'h01);
        chk("stale_30_p1", keycode_p1, 8'h4F);
        frame();
        chk("stale_31_p1", keycode_p1, 8'h00);
        chk("stale_31", {7'd0, stale}, 8'h01);
        send(64'h1A, 1);
        chk("stale_cleared", {7'd0, stale}, 8'h00);

        // reset in the middle of a report
        step(1'b1, 8'h1A, 1'b0, fl, 1'b0);
        step(1'b1, 8'h2C, 1'b0, fl, 1'b0);
        step(1'b0, 8'h00, 1'b0, fl, 1'b1);
        chk("midreset_p0", keycode_p0, 8'h00);
        chk("midreset_p1", keycode_p1, 8'h00);
        chk("midreset_stale", {7'd0, stale}, 8'h00);
        send(64'h16, 1);
        frame();
        chk("after_reset_p0", keycode_p0, 8'h16);

        // commit on the same edge as the frame pulse: old pending is shown
        send(64'h04, 1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'h07, 1'b1, 1'b1, 1'b0);
        chk("collide_old_p0", keycode_p0, 8'h04);
        chk("collide_stale", {7'd0, stale}, 8'h00);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        fl = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, fl, 1'b0);
        frame();
        chk("collide_new_p0", keycode_p0, 8'h07);

        // random traffic against the model
        begin
            int fcnt;
            fcnt = 5;
            for (int c = 0; c < 4000; c++) begin
                logic [7:0] b;
                if ($urandom_range(0, 7) == 0) b = 8'($urandom);
                else b = codes[$urandom_range(0, 15)];
                if (fcnt == 0) begin
                    fl = !fl;
                    fcnt = $urandom_range(2, 20);
                end else begin
                    fcnt--;
                end
                step($urandom_range(0, 2) != 0, b, $urandom_range(0, 3) == 0, fl,
                     $urandom_range(0, 499) == 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
